// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises i_rx, gates the baud prescaler and frames received words.
// Define UART_RX_PARITY_EN to add a parity bit check (ParityOdd, o_parity_err).

module uart_rx_framer #(
   parameter int unsigned DataBits   = 8,
   parameter int unsigned SyncStages = 2
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit          ParityOdd  = 1'b0
`endif
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_rx,
   input  logic                i_strobe,
   input  logic                i_half,
   output logic                o_presc_en,
   output logic [DataBits-1:0] o_data,
   output logic                o_valid,
   input  logic                i_ready,
`ifdef UART_RX_PARITY_EN
   output logic                o_parity_err,
`endif
   output logic                o_frame_err,
   output logic                o_overrun
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StPark
   } state_e;

   localparam logic [2:0] IdxLast = 3'(DataBits - 1);

   logic [SyncStages-1:0] sync_q, sync_d;
   logic                  rx_s;
   state_e                state_q, state_d;
   logic                  presc_en_q, presc_en_d;
   logic                  start_ok_q, start_ok_d;
   logic                  start_valid;
   logic [2:0]            bit_idx_q, bit_idx_d;
   logic [DataBits-1:0]   shift_q, shift_d;
   logic [DataBits-1:0]   data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic                  commit;
`ifdef UART_RX_PARITY_EN
   logic                  par_bad_q, par_bad_d;
   logic                  parity_err_q, parity_err_d;
   logic                  par_mismatch;
`endif

   assign sync_d = {sync_q[SyncStages-2:0], i_rx};
   assign rx_s   = sync_q[SyncStages-1];

   // i_half is evaluated before i_strobe, so a same-cycle half can still validate the start
   assign start_valid = start_ok_q | (i_half & ~rx_s);

`ifdef UART_RX_PARITY_EN
   assign par_mismatch = rx_s != ((^shift_q) ^ ParityOdd);
`endif

   always_comb begin
      state_d     = state_q;
      presc_en_d  = presc_en_q;
      start_ok_d  = start_ok_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (!rx_s) begin
               state_d    = StStart;
               presc_en_d = 1'b1;
               start_ok_d = 1'b0;
            end
         end
         StStart: begin
            start_ok_d = start_valid;
            // A false start still waits for the strobe so PARK leaves the counter at 0
            if (i_strobe) begin
               if (start_valid) begin
                  state_d   = StData;
                  bit_idx_d = '0;
               end else begin
                  state_d = StPark;
               end
            end
         end
         StData: begin
            if (i_half) begin
               shift_d = {rx_s, shift_q[DataBits-1:1]};
            end
            if (i_strobe) begin
               if (bit_idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                  state_d   = StParity;
                  par_bad_d = 1'b0;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (i_half) begin
               par_bad_d    = par_mismatch;
               parity_err_d = par_mismatch;
            end
            if (i_strobe) begin
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (i_half) begin
`ifdef UART_RX_PARITY_EN
               commit = rx_s & ~par_bad_q;
`else
               commit = rx_s;
`endif
               frame_err_d = ~rx_s;
            end
            if (i_strobe) begin
               state_d = StPark;
            end
         end
         StPark: begin
            state_d    = StIdle;
            presc_en_d = 1'b0;
         end
         default: begin
            state_d    = StIdle;
            presc_en_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      overrun_d = 1'b0;
      if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
      if (commit) begin
         if (valid_q && !i_ready) begin
            overrun_d = 1'b1;
         end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q       <= '1;
         state_q      <= StIdle;
         presc_en_q   <= 1'b0;
         start_ok_q   <= 1'b0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         presc_en_q   <= presc_en_d;
         start_ok_q   <= start_ok_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign o_presc_en  = presc_en_q;
   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- UART receive framer. Sits directly downstream of the UART baud prescaler and consumes its strobe and halfway outputs.
- Synchronises the serial input and gates the prescaler enable.
- Samples start, data and stop bits at mid-bit; advances bit position on each bit strobe.
- Presents each received word on a one-entry valid/ready output register, with framing-error and overrun flags.

Parameters:
DataBits, 8, data bits per frame (legal 5..8), LSB first
SyncStages, 2, flops in the i_rx synchroniser chain (legal 2..4)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  serial line, asynchronous, idle high
i_strobe  input  1  bit-period strobe from prescaler (one cycle per bit)
i_half  input  1  mid-bit strobe from prescaler (one cycle per bit)
o_presc_en  output  1  registered enable to prescaler
o_data  output  DataBits  received word
o_valid  output  1  o_data holds an unconsumed word
i_ready  input  1  consumer accepts o_data when o_valid && i_ready
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: word completed while o_valid && !i_ready

Behaviour:
- Reset: all of the following clear asynchronously.
  - Synchroniser flops reset to 1.
  - State=IDLE; o_presc_en, o_valid, o_frame_err, o_overrun = 0; o_data = 0.
- rx_s is the synchroniser output, SyncStages cycles of latency. All decisions use rx_s only.
- Prescaler contract:
  - The prescaler counter holds its value while disabled.
  - This block always parks the counter at 0 before dropping o_presc_en, so that i_half lands at mid-bit of the next start bit.
- FSM states: IDLE, START, DATA, [PARITY], STOP, PARK.
- IDLE: rx_s==0 -> START, o_presc_en<=1 at the same edge.
- START:
  - On i_half, rx_s==1 is a false start -> PARK; no flags raised.
  - On i_half, rx_s==0 marks the start as valid.
  - On i_strobe after a valid start -> DATA, bit index=0.
- DATA:
  - On i_half, shift rx_s into a shift register, LSB first.
  - On i_strobe, if index==DataBits-1 -> PARITY (when compiled) else STOP; otherwise index+1.
- STOP:
  - On i_half, sample the stop bit.
    - Stop bit 1: commit the word to the output register.
    - Stop bit 0: pulse o_frame_err for one cycle and discard the word.
  - On i_strobe -> PARK.
- PARK:
  - o_presc_en stays 1 for exactly one further cycle, so the prescaler wraps to 0.
  - o_presc_en<=0 and state<=IDLE at the edge ending that cycle.
  - rx_s is ignored during PARK.
- i_half and i_strobe are never asserted together for legal scaler values (>=6). If both are seen, i_half is processed first.
- Output register:
  - A commit sets o_valid=1 and o_data=word.
  - A handshake (o_valid && i_ready) clears o_valid at the next edge.
  - Commit in the same cycle as a handshake: load the new word, o_valid stays 1, no overrun.
  - Commit while o_valid && !i_ready: the new word is dropped, old o_data is held, and o_overrun pulses one cycle.
  - o_data is stable while o_valid=1.
- Latency: o_valid rises on the edge after the i_half cycle of the stop bit.
- Reset mid-frame: immediate return to the reset state; a partial word is lost.
  - The prescaler is also reset on the shared i_rst_n, so the counter realigns.
- A line held low indefinitely produces repeated frame errors, one per 10-bit frame time (8N1), with no o_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, plus parameter ParityOdd (default 0 = even).
  - On i_half in PARITY, compare rx_s with the XOR of the data bits, inverted when ParityOdd=1.
  - Adds output o_parity_err (1 bit), a one-cycle pulse on mismatch. A mismatched word is discarded and not committed.
  - Frame time becomes 1+DataBits+1+1 bits.
- Undefined: no PARITY state and no o_parity_err port; DATA goes directly to STOP.

Test Plan:
- Scaler 16, send 0xA5 8N1, i_ready=1 -> o_valid pulses one cycle with o_data=0xA5. No flags. o_presc_en low and prescaler counter=0 afterwards.
- Glitch: i_rx low for 4 cycles, then high -> FSM returns to IDLE via PARK. No o_valid, no o_frame_err. Counter parked at 0.
- Send 0x3C with stop bit forced 0 -> o_frame_err pulses one cycle. o_valid stays 0.
- i_ready=0, send 0x11 then 0x22 back-to-back -> o_data=0x11, o_valid=1 held, o_overrun pulses once at the second commit. Raise i_ready -> o_valid clears next edge.
- i_ready asserted in the exact commit cycle of the second word -> o_data=0x22, o_valid stays 1, no o_overrun.
- UART_RX_PARITY_EN defined, ParityOdd=0, send 0x07 with parity bit 0 (should be 1) -> o_parity_err pulse, no o_valid. Assert i_rst_n low mid-DATA on a later frame -> all outputs 0 immediately.
